// File: rtl/ptcalc_poly_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ptcalc_poly_pkg
// Brief    : Shared widths, FSM state type and 28-bit clamp helper for the
//            pT polynomial evaluator.
// Revision : 1.0
// ============================================================================
package ptcalc_poly_pkg;

    localparam int X_W = 16;
    localparam int C_W = 28;
    localparam int P_W = 44;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Returns {clamped, value}: value limited to [-2^27, 2^27-1].
    function automatic logic [C_W:0] sat28(input logic signed [P_W:0] v);
        logic [C_W:0] res;
        if ((v[P_W:C_W-1] == '0) || (v[P_W:C_W-1] == '1)) begin
            res = {1'b0, v[C_W-1:0]};
        end else if (v[P_W]) begin
            res = {1'b1, 1'b1, {(C_W-1){1'b0}}};
        end else begin
            res = {1'b1, 1'b0, {(C_W-1){1'b1}}};
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptcalc_poly_rnd_sat.sv
`default_nettype none
// ============================================================================
// Module   : ptcalc_poly_rnd_sat
// Brief    : Round-half-up, shift and coefficient add for one Horner step.
//            PTCALC_POLY_SAT_EN selects clamping instead of wrap on reduction.
// Revision : 1.0
// ============================================================================
module ptcalc_poly_rnd_sat
    import ptcalc_poly_pkg::*;
#(
    parameter int FRAC = 16
) (
    input  logic signed [P_W-1:0] i_prod,
    input  logic signed [C_W-1:0] i_coef,
    output logic signed [C_W-1:0] o_acc,
    output logic                  o_sat
);

    localparam logic signed [P_W:0] c_half = {{P_W{1'b0}}, 1'b1} << (FRAC - 1);

    logic signed [P_W:0] w_rsum;
    logic signed [P_W:0] w_r;
    logic signed [C_W-1:0] w_r28;
    logic signed [C_W:0] w_s;

    // One guard bit above the product so the rounding offset never overflows.
    assign w_rsum = {i_prod[P_W-1], i_prod} + c_half;
    assign w_r    = w_rsum >>> FRAC;
    assign w_s    = {w_r28[C_W-1], w_r28} + {i_coef[C_W-1], i_coef};

`ifdef PTCALC_POLY_SAT_EN
    logic [C_W:0] w_rc;
    logic [C_W:0] w_sc;

    assign w_rc  = sat28(w_r);
    assign w_r28 = w_rc[C_W-1:0];
    assign w_sc  = sat28({{(P_W-C_W){w_s[C_W]}}, w_s});
    assign o_acc = w_sc[C_W-1:0];
    assign o_sat = w_rc[C_W] | w_sc[C_W];
`else
    logic w_unused;

    assign w_r28    = w_r[C_W-1:0];
    assign o_acc    = w_s[C_W-1:0];
    assign o_sat    = 1'b0;
    assign w_unused = ^{w_r[P_W:C_W], w_s[C_W]};
`endif

endmodule
`default_nettype wire

// File: rtl/ptcalc_poly_eval.sv
`default_nettype none
// ============================================================================
// Module   : ptcalc_poly_eval
// Brief    : Iterative Horner polynomial evaluator producing a 28-bit pT word.
//            PTCALC_POLY_SAT_EN enables saturating reductions and out_sat.
// Revision : 1.0
// ============================================================================
module ptcalc_poly_eval
    import ptcalc_poly_pkg::*;
#(
    parameter int N_COEF = 4,
    parameter int FRAC   = 16
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [X_W-1:0]            x_i,
    input  logic                      coef_we,
    input  logic [$clog2(N_COEF)-1:0] coef_addr,
    input  logic [C_W-1:0]            coef_wdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [C_W-1:0]            pt_o,
    output logic                      out_sat
);

    localparam int c_kw = $clog2(N_COEF);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [X_W-1:0]        r_x;
    logic signed [C_W-1:0] r_acc;
    logic signed [P_W-1:0] r_prod;
    logic [c_kw-1:0]       r_k;
    logic                  r_sat;
    logic signed [C_W-1:0] r_coef [N_COEF];

    logic signed [P_W-1:0] w_xe;
    logic signed [P_W-1:0] w_ae;
    logic signed [P_W-1:0] w_prod;
    logic signed [C_W-1:0] w_acc_nxt;
    logic                  w_sat;
    logic                  w_addr_ok;

    // x is unsigned, so it is zero-extended before the signed multiply.
    assign w_xe      = {{(P_W-X_W){1'b0}}, r_x};
    assign w_ae      = {{(P_W-C_W){r_acc[C_W-1]}}, r_acc};
    assign w_prod    = w_xe * w_ae;
    assign w_addr_ok = (32'(coef_addr) < 32'(N_COEF));

    ptcalc_poly_rnd_sat #(
        .FRAC (FRAC)
    ) u_rnd_sat (
        .i_prod (r_prod),
        .i_coef (r_coef[r_k]),
        .o_acc  (w_acc_nxt),
        .o_sat  (w_sat)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_nxt = ST_MUL;
            ST_MUL:  w_state_nxt = ST_ACC;
            ST_ACC:  w_state_nxt = (r_k == '0) ? ST_DONE : ST_MUL;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        pt_o      = (r_state == ST_DONE) ? r_acc : '0;
        out_sat   = (r_state == ST_DONE) & r_sat;
    end

    // A write coincident with the accepting handshake lands after the
    // evaluation has already latched c[N_COEF-1].
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_x    <= '0;
            r_acc  <= '0;
            r_prod <= '0;
            r_k    <= '0;
            r_sat  <= 1'b0;
            for (int i = 0; i < N_COEF; i++) begin
                r_coef[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (coef_we && w_addr_ok) begin
                        r_coef[coef_addr] <= coef_wdata;
                    end
                    if (in_valid) begin
                        r_x   <= x_i;
                        r_acc <= r_coef[N_COEF-1];
                        r_k   <= c_kw'(N_COEF - 2);
                        r_sat <= 1'b0;
                    end
                end
                ST_MUL: begin
                    r_prod <= w_prod;
                end
                ST_ACC: begin
                    r_acc <= w_acc_nxt;
                    r_sat <= r_sat | w_sat;
                    if (r_k != '0) begin
                        r_k <= r_k - c_kw'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ptcalc_poly_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_ptcalc_poly_eval
// Brief    : Directed self-checking bench for ptcalc_poly_eval (N_COEF=4,
//            FRAC=16); expectations follow PTCALC_POLY_SAT_EN when defined.
// Revision : 1.0
// ============================================================================
module tb_ptcalc_poly_eval;

    logic        ap_clk;
    logic        ap_rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_i;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [27:0] coef_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [27:0] pt_o;
    logic        out_sat;

    int n_vec;
    int n_err;

    ptcalc_poly_eval #(
        .N_COEF (4),
        .FRAC   (16)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x_i        (x_i),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pt_o       (pt_o),
        .out_sat    (out_sat)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [27:0] d);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = d;
        tick();
        coef_we    = 1'b0;
    endtask

    // wr_at = edge index (0 = handshake edge) carrying a coefficient write; -1 = none
    task automatic run(input string tag, input logic [15:0] x, input logic [27:0] exp_pt,
                       input logic exp_sat, input int wr_at, input logic [1:0] wa,
                       input logic [27:0] wd);
        x_i      = x;
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            coef_we    = (wr_at == i);
            coef_addr  = wa;
            coef_wdata = wd;
            if (i == 6) chk({tag, "_early"}, 32'(out_valid), 32'd0);
            tick();
            in_valid = 1'b0;
            coef_we  = 1'b0;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pt"}, 32'(pt_o), 32'(exp_pt));
        chk({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
        if (out_ready) begin
            tick();
            chk({tag, "_idle"}, 32'(in_ready), 32'd1);
        end
    endtask

    logic ever_valid;

    initial begin
        n_vec      = 0;
        n_err      = 0;
        ap_rst     = 1'b1;
        in_valid   = 1'b0;
        x_i        = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        out_ready  = 1'b1;
        tick();
        tick();
        ap_rst = 1'b0;

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pt", 32'(pt_o), 32'd0);
        chk("rst_sat", 32'(out_sat), 32'd0);

        // 100 + 1.0*x with x = 3/65536 -> 3 after rounding, so 103
        wr(2'd0, 28'd100);
        wr(2'd1, 28'd65536);
        run("lin", 16'd3, 28'd103, 1'b0, -1, 2'd0, 28'd0);

        // 0.5 * (1/65536) rounds half up to 1; -0.5 rounds up to 0
        wr(2'd0, 28'd0);
        wr(2'd1, 28'd32768);
        run("half_pos", 16'd1, 28'd1, 1'b0, -1, 2'd0, 28'd0);
        wr(2'd1, 28'(-32768));
        run("half_neg", 16'd1, 28'd0, 1'b0, -1, 2'd0, 28'd0);

        // r = 134215679, s = 268433406 overflows 28 bits
        wr(2'd0, 28'd134217727);
        wr(2'd1, 28'd134217727);
`ifdef PTCALC_POLY_SAT_EN
        run("ovf", 16'd65535, 28'd134217727, 1'b1, -1, 2'd0, 28'd0);
`else
        run("ovf", 16'd65535, 28'(-2050), 1'b0, -1, 2'd0, 28'd0);
`endif

        // backpressure: hold DONE, in_valid pulses must be ignored
        wr(2'd0, 28'd100);
        wr(2'd1, 28'd65536);
        out_ready = 1'b0;
        run("bp", 16'd3, 28'd103, 1'b0, -1, 2'd0, 28'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            x_i      = 16'd9;
            tick();
            chk("bp_hold_pt", 32'(pt_o), 32'd103);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_rel_valid", 32'(out_valid), 32'd0);
        chk("bp_rel_ready", 32'(in_ready), 32'd1);

        // write during MUL is dropped; the same write in IDLE takes effect
        run("mulwr", 16'd3, 28'd103, 1'b0, 1, 2'd0, 28'd500);
        run("mulwr_chk", 16'd3, 28'd103, 1'b0, -1, 2'd0, 28'd0);
        wr(2'd0, 28'd500);
        run("idlewr", 16'd3, 28'd503, 1'b0, -1, 2'd0, 28'd0);

        // write coincident with handshake: old c3=0 -> 32868, then c3=4096 -> 33380
        wr(2'd0, 28'd100);
        run("coin_old", 16'd32768, 28'd32868, 1'b0, 0, 2'd3, 28'd4096);
        run("coin_new", 16'd32768, 28'd33380, 1'b0, -1, 2'd0, 28'd0);

        // reset during ACC discards the evaluation and clears coefficients
        x_i      = 16'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_pt", 32'(pt_o), 32'd0);
        ever_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            ever_valid = ever_valid | out_valid;
        end
        chk("arst_no_stale", 32'(ever_valid), 32'd0);
        run("arst_x5", 16'd5, 28'd0, 1'b0, -1, 2'd0, 28'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ptcalc_poly_eval.md
# ptcalc_poly_eval

Iterative Horner-scheme polynomial evaluator for the pT-calculation path. It accepts one 16-bit unsigned segment variable x, typically a fixed-point inverse sagitta. Each step multiplies x by a running 28-bit signed accumulator with a 16 × 28 → 44-bit signed product, then rounds, shifts and adds the next coefficient. It emits a 28-bit signed pT word. The block both feeds the multiplier and consumes its product, and sits between segment formatting and the pT output register.

## Interface
- N_COEF, 4: polynomial length (c[0]..c[N_COEF-1]); legal range 2..16.
- FRAC, 16: fractional bits of x; product is shifted right by FRAC; legal range 1..20.
- ap_clk  in  1  single clock, rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- in_valid  in  1  x_i valid.
- in_ready  out  1  block can accept x_i.
- x_i  in  16  unsigned variable.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(N_COEF)  coefficient index.
- coef_wdata  in  28  signed coefficient.
- out_valid  out  1  pt_o valid.
- out_ready  in  1  downstream accepts pt_o.
- pt_o  out  28  signed result.
- out_sat  out  1  a saturation occurred during this evaluation; only meaningful with the macro.

## Operation
- FSM states: IDLE, MUL, ACC, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid: x_r<=x_i, acc<=c[N_COEF-1], k<=N_COEF-2, sat_r<=0, go MUL.
- **MUL**
  - prod_r <= $signed({1'b0,x_r}) * acc, a full 44-bit signed product.
  - Go ACC.
- **ACC**
  - Rounding: r = (prod_r + 2^(FRAC-1)) >>> FRAC. This is round-half-up toward +inf.
  - Reduce r to 28 bits, then form s = r + c[k] at 29 bits and reduce to 28.
  - Result goes to acc.
  - If k==0 go DONE, else k<=k-1 and go MUL.
- **DONE**
  - out_valid=1, pt_o=acc, out_sat=sat_r.
  - On out_ready: go IDLE.
- Coefficient writes:
  - Accepted only in IDLE; c[coef_addr]<=coef_wdata.
  - Writes in any other state are dropped silently.
  - A write with coef_addr ≥ N_COEF is ignored.
  - A write coincident with an accepted in_valid is accepted, but that evaluation uses the old value.
- The shifted 44-bit value is reduced to 28 bits according to the configuration macro.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, pt_o=0, out_sat=0.
  - acc, x_r, prod_r and k all 0.
  - All coefficients 0.
- Latency: out_valid rises 2·(N_COEF-1)+1 cycles after the in_valid/in_ready handshake cycle. This is 7 cycles for N_COEF=4.
- Throughput: at most one evaluation per 2·(N_COEF-1)+2 cycles with out_ready held high.
- Backpressure: while out_ready=0 in DONE, pt_o and out_sat stay stable and in_ready stays 0.
- in_ready is combinational from state only; there is no path from in_valid.
- ap_rst asserted in any state returns to IDLE on the next edge and clears coefficients. An in-flight result is discarded and never presented.

## Configuration
- Macro: PTCALC_POLY_SAT_EN.
- **Defined**
  - Both the r reduction and the s reduction clamp to [-2^27, 2^27-1].
  - Any clamp sets sat_r.
- **Undefined**
  - Reductions are plain two's-complement truncation (wrap).
  - out_sat is tied 0.

## Structure
- Package ptcalc_poly_pkg holds:
  - width constants X_W=16, C_W=28, P_W=44;
  - the state enum typedef;
  - a sat28 function.
- Sub-module ptcalc_poly_rnd_sat is combinational. It takes prod_r, c[k] and FRAC and returns the next acc plus a sat flag.
- The multiply stays inline in the top level so that it maps to one DSP.

## Test plan
- Coefficients c0=100, c1=65536, c2=c3=0; x=3 -> pt_o=103 exactly 7 cycles after the handshake; out_sat=0.
- Coefficients c1=32768, c0=0, others 0:
  - x=1 -> pt_o=1 (round half up);
  - with c1=-32768 -> pt_o=0.
- Macro defined, c1=c0=134217727, x=65535 -> pt_o=134217727, out_sat=1. Macro undefined, same stimulus -> pt_o equals the 28-bit wrapped sum, out_sat=0.
- Hold out_ready=0 for 5 cycles in DONE -> pt_o stable, in_ready=0, and in_valid pulses are ignored. Then out_ready=1 -> IDLE next cycle.
- Coefficient write to c0 issued while in MUL -> dropped. The result is unchanged versus the prior run, and the same write in IDLE takes effect on the next run.
- Assert ap_rst during ACC -> next cycle out_valid=0, in_ready=1, all coefficients read back 0, and x=5 then yields pt_o=0.
